// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Imported by the handshake FSM and the stage top.
package mem_access_stage_pkg;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

endpackage

// File: rtl/mem_access_stage_handshake.sv
// Data-memory req/ack handshake: request, stall, timeout abort
// and the sticky error flag.
import mem_access_stage_pkg::*;

module mem_handshake_fsm #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_op,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic stall,
  output logic abort,
  output logic mem_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req     = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          req = 1'b1;
          // the request cycle itself is cycle 0 of the budget
          if (!dmem_ack) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          abort   = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // req must fall the moment reset asserts, not at the next edge
  assign dmem_req = req & rst_n;
  assign stall    = dmem_req & ~dmem_ack & ~abort;
  assign mem_err  = err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: branch redirect, data-memory access and the
// MEM/WB boundary register.
import mem_access_stage_pkg::*;

module mem_access_stage #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_EXMem,
  input  logic        rst_EXMem,
  input  logic [31:0] PC_in,
  input  logic [31:0] PC4_in,
  input  logic [4:0]  Rd_addr_in,
  input  logic        zero_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] Rs2_in,
  input  logic        Branch_in,
  input  logic        BranchN_in,
  input  logic        Jump_in,
  input  logic        MemRW_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic        RegWrite_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        PCSrc_out,
  output logic [31:0] target_out,
  output logic [4:0]  Rd_addr_MemWB,
  output logic        RegWrite_MemWB,
  output logic [31:0] wb_data_MemWB,
  output logic        mem_err
);

  logic        mem_op;
  logic        abort;
  logic [31:0] wb_sel;

  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [31:0] wb_q, wb_d;

  assign mem_op = MemRW_in | (MemtoReg_in == MTR_MEM);

  mem_handshake_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk      (clk_EXMem),
    .rst_n    (rst_EXMem),
    .mem_op   (mem_op),
    .dmem_ack (dmem_ack),
    .dmem_req (dmem_req),
    .stall    (stall_out),
    .abort    (abort),
    .mem_err  (mem_err)
  );

  assign dmem_we    = dmem_req & MemRW_in;
  assign dmem_addr  = ALU_in;
  assign dmem_wdata = Rs2_in;

  assign PCSrc_out = Jump_in
                   | (Branch_in & zero_in)
                   | (BranchN_in & ~zero_in);
  assign target_out = PC_in;

  always_comb begin
    wb_sel = ALU_in;
    unique case (MemtoReg_in)
      MTR_MEM: wb_sel = dmem_rdata;
      MTR_PC4: wb_sel = PC4_in;
      default: wb_sel = ALU_in;
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    wb_d = wb_q;
    rw_d = 1'b0;
    if (!stall_out) begin
      rd_d = Rd_addr_in;
      wb_d = wb_sel;
      rw_d = RegWrite_in & ~abort;
    end
  end

  always_ff @(posedge clk_EXMem or negedge rst_EXMem) begin
    if (!rst_EXMem) begin
      rd_q <= '0;
      rw_q <= 1'b0;
      wb_q <= '0;
    end else begin
      rd_q <= rd_d;
      rw_q <= rw_d;
      wb_q <= wb_d;
    end
  end

  assign Rd_addr_MemWB  = rd_q;
  assign RegWrite_MemWB = rw_q;
  assign wb_data_MemWB  = wb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage.
// Each task drives one scenario and checks inline.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC_in, PC4_in, ALU_in, Rs2_in, rdata;
  logic [4:0]  Rd_in;
  logic        zero, br, brn, jmp, memrw, regw, ack;
  logic [1:0]  mtr;
  logic        req, we, stall, pcsrc, rw_wb, err;
  logic [31:0] addr, wdata, target, wb;
  logic [4:0]  rd_wb;

  int tests = 0;
  int fails = 0;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk_EXMem      (clk),
    .rst_EXMem      (rst),
    .PC_in          (PC_in),
    .PC4_in         (PC4_in),
    .Rd_addr_in     (Rd_in),
    .zero_in        (zero),
    .ALU_in         (ALU_in),
    .Rs2_in         (Rs2_in),
    .Branch_in      (br),
    .BranchN_in     (brn),
    .Jump_in        (jmp),
    .MemRW_in       (memrw),
    .MemtoReg_in    (mtr),
    .RegWrite_in    (regw),
    .dmem_req       (req),
    .dmem_we        (we),
    .dmem_addr      (addr),
    .dmem_wdata     (wdata),
    .dmem_ack       (ack),
    .dmem_rdata     (rdata),
    .stall_out      (stall),
    .PCSrc_out      (pcsrc),
    .target_out     (target),
    .Rd_addr_MemWB  (rd_wb),
    .RegWrite_MemWB (rw_wb),
    .wb_data_MemWB  (wb),
    .mem_err        (err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop;
    PC_in = 32'h0; PC4_in = 32'h4; ALU_in = 32'h0;
    Rs2_in = 32'h0; rdata = 32'h0; Rd_in = 5'd0;
    zero = 1'b0; br = 1'b0; brn = 1'b0; jmp = 1'b0;
    memrw = 1'b0; mtr = 2'b00; regw = 1'b0; ack = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] a);
    set_nop;
    Rd_in = rd; ALU_in = a; mtr = 2'b01; regw = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({req, stall, rw_wb, err} !== 4'b0 || wb !== 32'h0
        || rd_wb !== 5'd0) begin
      fails++;
      $display("FAIL reset: req=%b stall=%b rw=%b err=%b wb=%h rd=%0d, want all 0",
               req, stall, rw_wb, err, wb, rd_wb);
    end
  endtask

  task automatic test_alu;
    set_nop;
    ALU_in = 32'h1234; regw = 1'b1; Rd_in = 5'd5;
    #1;
    tests++;
    if (stall !== 1'b0 || req !== 1'b0) begin
      fails++;
      $display("FAIL alu_nostall: stall=%b req=%b, want 0 0", stall, req);
    end
    step;
    tests++;
    if (wb !== 32'h1234 || rw_wb !== 1'b1 || rd_wb !== 5'd5) begin
      fails++;
      $display("FAIL alu_wb: wb=%h rw=%b rd=%0d, want 00001234 1 5",
               wb, rw_wb, rd_wb);
    end
    mtr = 2'b10; PC4_in = 32'h88; Rd_in = 5'd6;
    step;
    tests++;
    if (wb !== 32'h88 || rd_wb !== 5'd6) begin
      fails++;
      $display("FAIL pc4_wb: wb=%h rd=%0d, want 00000088 6", wb, rd_wb);
    end
  endtask

  task automatic test_branch;
    set_nop;
    brn = 1'b1; zero = 1'b0; PC_in = 32'h40;
    #1;
    tests++;
    if (pcsrc !== 1'b1 || target !== 32'h40) begin
      fails++;
      $display("FAIL bne_taken: pcsrc=%b target=%h, want 1 00000040",
               pcsrc, target);
    end
    zero = 1'b1;
    #1;
    tests++;
    if (pcsrc !== 1'b0) begin
      fails++;
      $display("FAIL bne_not_taken: pcsrc=%b, want 0", pcsrc);
    end
    brn = 1'b0; br = 1'b1;
    #1;
    tests++;
    if (pcsrc !== 1'b1) begin
      fails++;
      $display("FAIL beq_taken: pcsrc=%b, want 1", pcsrc);
    end
    br = 1'b0; zero = 1'b0; jmp = 1'b1;
    #1;
    tests++;
    if (pcsrc !== 1'b1) begin
      fails++;
      $display("FAIL jump: pcsrc=%b, want 1", pcsrc);
    end
    set_nop;
    step;
  endtask

  task automatic test_store;
    set_nop;
    ALU_in = 32'h100; Rs2_in = 32'hA5A5A5A5; memrw = 1'b1; ack = 1'b1;
    #1;
    tests++;
    if (req !== 1'b1 || we !== 1'b1 || addr !== 32'h100
        || wdata !== 32'hA5A5A5A5 || stall !== 1'b0) begin
      fails++;
      $display("FAIL store_bus: req=%b we=%b addr=%h wdata=%h stall=%b, want 1 1 00000100 a5a5a5a5 0",
               req, we, addr, wdata, stall);
    end
    step;
    set_nop;
    tests++;
    if (rw_wb !== 1'b0) begin
      fails++;
      $display("FAIL store_rw: rw=%b, want 0", rw_wb);
    end
  endtask

  task automatic test_load_wait;
    int sc;
    set_nop;
    ALU_in = 32'h1; regw = 1'b1; Rd_in = 5'd1;
    step;
    set_load(5'd7, 32'h200);
    sc = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall === 1'b1 && we === 1'b0) sc++;
      step;
      tests++;
      if (rw_wb !== 1'b0) begin
        fails++;
        $display("FAIL load_bubble: cycle %0d rw=%b, want 0", i, rw_wb);
      end
    end
    tests++;
    if (sc != 3) begin
      fails++;
      $display("FAIL load_stall_cnt: %0d cycles, want 3", sc);
    end
    ack = 1'b1; rdata = 32'hDEADBEEF;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL load_ack_stall: stall=%b, want 0", stall);
    end
    step;
    set_nop;
    tests++;
    if (wb !== 32'hDEADBEEF || rw_wb !== 1'b1 || rd_wb !== 5'd7) begin
      fails++;
      $display("FAIL load_wb: wb=%h rw=%b rd=%0d, want deadbeef 1 7",
               wb, rw_wb, rd_wb);
    end
  endtask

  task automatic test_ack_at_timeout;
    int sc;
    set_load(5'd8, 32'h300);
    sc = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (stall === 1'b1) sc++;
      step;
    end
    ack = 1'b1; rdata = 32'hCAFEF00D;
    #1;
    tests++;
    if (sc != 15 || stall !== 1'b0) begin
      fails++;
      $display("FAIL ackto_stall: cnt=%0d stall=%b, want 15 0", sc, stall);
    end
    step;
    set_nop;
    tests++;
    if (err !== 1'b0 || rw_wb !== 1'b1 || wb !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL ackto_wb: err=%b rw=%b wb=%h, want 0 1 cafef00d",
               err, rw_wb, wb);
    end
  endtask

  task automatic test_ack_ignored;
    set_nop;
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    ALU_in = 32'h55; regw = 1'b1; Rd_in = 5'd3;
    #1;
    tests++;
    if (req !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL ign_bus: req=%b stall=%b, want 0 0", req, stall);
    end
    step;
    set_nop;
    tests++;
    if (wb !== 32'h55 || err !== 1'b0 || rd_wb !== 5'd3) begin
      fails++;
      $display("FAIL ign_wb: wb=%h err=%b rd=%0d, want 00000055 0 3",
               wb, err, rd_wb);
    end
  endtask

  task automatic test_timeout;
    int sc;
    set_load(5'd9, 32'h400);
    sc = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (stall !== 1'b1) break;
      sc++;
      step;
      #1;
    end
    tests++;
    if (sc != 15 || req !== 1'b1) begin
      fails++;
      $display("FAIL to_stall: cnt=%0d req=%b, want 15 1", sc, req);
    end
    step;
    set_nop;
    tests++;
    if (err !== 1'b1 || rw_wb !== 1'b0) begin
      fails++;
      $display("FAIL to_abort: err=%b rw=%b, want 1 0", err, rw_wb);
    end
    ALU_in = 32'h77; regw = 1'b1; Rd_in = 5'd4;
    #1;
    tests++;
    if (stall !== 1'b0 || req !== 1'b0) begin
      fails++;
      $display("FAIL to_next_bus: stall=%b req=%b, want 0 0", stall, req);
    end
    step;
    set_nop;
    tests++;
    if (wb !== 32'h77 || rw_wb !== 1'b1 || err !== 1'b1) begin
      fails++;
      $display("FAIL to_next_wb: wb=%h rw=%b err=%b, want 00000077 1 1",
               wb, rw_wb, err);
    end
  endtask

  task automatic test_reset_mid_wait;
    set_load(5'd10, 32'h500);
    step;
    step;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (req !== 1'b0 || stall !== 1'b0 || rw_wb !== 1'b0
        || wb !== 32'h0 || rd_wb !== 5'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: req=%b stall=%b rw=%b wb=%h rd=%0d err=%b, want all 0",
               req, stall, rw_wb, wb, rd_wb, err);
    end
    set_nop;
    step;
    rst = 1'b1;
    #1;
    tests++;
    if (req !== 1'b0) begin
      fails++;
      $display("FAIL rst_idle: req=%b, want 0", req);
    end
  endtask

  initial begin
    set_nop;
    @(posedge clk);
    test_reset;
    rst = 1'b1;
    step;
    test_alu;
    test_branch;
    test_store;
    test_load_wait;
    test_ack_at_timeout;
    test_ack_ignored;
    test_timeout;
    test_reset_mid_wait;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
